// File: rtl/spi_led_pwm_ctrl_pkg.sv
// Shared definitions for the SPI LED PWM controller:
// frame layout, command codes and status bit positions.
package spi_led_pwm_ctrl_pkg;

  localparam int CMD_BITS     = 8;
  localparam int ADDR_BITS    = 8;
  localparam int PAYLOAD_BITS = 8;
  localparam int FRAME_WIDTH  = CMD_BITS + ADDR_BITS + PAYLOAD_BITS;

  localparam logic [CMD_BITS-1:0] CMD_NOP     = 8'h00;
  localparam logic [CMD_BITS-1:0] CMD_LED_SET = 8'h01;
  localparam logic [CMD_BITS-1:0] CMD_LED_GET = 8'h02;
  localparam logic [CMD_BITS-1:0] CMD_ALL_SET = 8'h03;
  localparam logic [CMD_BITS-1:0] CMD_FADE    = 8'h04;

  localparam int STATUS_BAD_LEN  = 0;
  localparam int STATUS_BAD_ADDR = 1;
  localparam int STATUS_BAD_CMD  = 2;

  typedef enum logic [1:0] {
    RX_DISARMED,
    RX_IDLE,
    RX_RECV
  } rx_state_e;

  typedef struct packed {
    logic [CMD_BITS-1:0]     cmd;
    logic [ADDR_BITS-1:0]    addr;
    logic [PAYLOAD_BITS-1:0] payload;
  } frame_t;

endpackage

// File: rtl/spi_led_pwm_ctrl_if.sv
// SPI bus bundle between an external master
// and the LED controller slave.
interface spi_led_pwm_ctrl_if;
  logic sclk;
  logic cs;
  logic mosi;
  logic miso;

  modport master (
    output sclk, cs, mosi,
    input  miso
  );

  modport slave (
    input  sclk, cs, mosi,
    output miso
  );
endinterface

// File: rtl/spi_led_pwm_ctrl_led_channel.sv
// One PWM channel: brightness, fade target,
// single-step fade and registered PWM compare.
module led_channel #(
  parameter int PWM_BITS = 7
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [PWM_BITS-1:0] cnt_i,
  input  logic                tick_i,
  input  logic                set_i,
  input  logic                fade_i,
  input  logic [PWM_BITS-1:0] data_i,
  output logic [PWM_BITS-1:0] bright_o,
  output logic                led_o
);
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [PWM_BITS-1:0] target_q, target_d;
  logic                led_q;

  // A write this cycle takes precedence over a fade step.
  always_comb begin
    bright_d = bright_q;
    target_d = target_q;
    if (set_i) begin
      bright_d = data_i;
      target_d = data_i;
    end else if (fade_i) begin
      target_d = data_i;
    end else if (tick_i && bright_q != target_q) begin
      if (bright_q < target_q) bright_d = bright_q + 1'b1;
      else                     bright_d = bright_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bright_q <= '0;
      target_q <= '0;
      led_q    <= 1'b0;
    end else begin
      bright_q <= bright_d;
      target_q <= target_d;
      led_q    <= cnt_i < bright_q;
    end
  end

  assign bright_o = bright_q;
  assign led_o    = led_q;
endmodule

// File: rtl/spi_led_pwm_ctrl.sv
// SPI mode-0 slave driving NUM_LEDS PWM channels with
// read-back, broadcast set and timed fading.
import spi_led_pwm_ctrl_pkg::*;

module spi_led_pwm_ctrl #(
  parameter int NUM_LEDS    = 8,
  parameter int PWM_BITS    = 7,
  parameter int FADE_DIV    = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic                sysclk,
  input  logic                rst_n,
  spi_led_pwm_ctrl_if.slave   spi,
  output logic [NUM_LEDS-1:0] led,
  output logic                rx_dv
);
  localparam int PRE_W = $clog2(FADE_DIV);
  localparam logic [PWM_BITS-1:0] CNT_MAX =
    PWM_BITS'((1 << PWM_BITS) - 2);
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(FADE_DIV - 1);
  localparam logic [4:0] LEN_OK  = 5'(FRAME_WIDTH);
  localparam logic [4:0] LEN_SAT = 5'(FRAME_WIDTH + 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  rx_state_e state_q, state_d;
  logic [FRAME_WIDTH-1:0] rx_q, tx_q, resp_q, resp_d;
  logic [4:0] bitcnt_q;
  logic [7:0] status_q, status_d;
  logic       rx_dv_q;
  logic [PWM_BITS-1:0] cnt_q;
  logic [PRE_W-1:0]    pre_q;
  logic                tick;

  frame_t fr;
  logic commit, bad_len, addr_ok, need_addr;
  logic is_set, is_get, is_all, is_fade, is_bad;
  logic [PWM_BITS-1:0] wr_data, rd_bright;
  logic [PWM_BITS-1:0] bright [NUM_LEDS];
  logic [NUM_LEDS-1:0] set_we, fade_we;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi.cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Disarmed until cs is seen high, so a frame cut by reset never commits.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RX_DISARMED: if (cs_s) state_d = RX_IDLE;
      RX_IDLE:     if (cs_fall) state_d = RX_RECV;
      RX_RECV:     if (cs_rise) state_d = RX_IDLE;
      default:     state_d = RX_DISARMED;
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) state_q <= RX_DISARMED;
    else        state_q <= state_d;
  end

  assign fr        = frame_t'(rx_q);
  assign commit    = state_q == RX_RECV && cs_rise && bitcnt_q == LEN_OK;
  assign bad_len   = state_q == RX_RECV && cs_rise && bitcnt_q != LEN_OK;
  assign addr_ok   = {1'b0, fr.addr} < 9'(NUM_LEDS);
  assign need_addr = is_set | is_get | is_fade;
  assign wr_data   = PWM_BITS'(fr.payload);

  always_comb begin
    is_set  = 1'b0;
    is_get  = 1'b0;
    is_all  = 1'b0;
    is_fade = 1'b0;
    is_bad  = 1'b0;
    unique case (fr.cmd)
      CMD_NOP:     begin end
      CMD_LED_SET: is_set  = 1'b1;
      CMD_LED_GET: is_get  = 1'b1;
      CMD_ALL_SET: is_all  = 1'b1;
      CMD_FADE:    is_fade = 1'b1;
      default:     is_bad  = 1'b1;
    endcase
  end

  always_comb begin
    rd_bright = '0;
    set_we    = '0;
    fade_we   = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (fr.addr == ADDR_BITS'(i)) rd_bright = bright[i];
      set_we[i]  = commit &&
                   (is_all || (is_set && fr.addr == ADDR_BITS'(i)));
      fade_we[i] = commit && is_fade && fr.addr == ADDR_BITS'(i);
    end
  end

  always_comb begin
    status_d = status_q;
    resp_d   = resp_q;
    if (bad_len) status_d[STATUS_BAD_LEN] = 1'b1;
    if (commit) begin
      unique case (1'b1)
        is_bad: status_d[STATUS_BAD_CMD] = 1'b1;
        need_addr && !addr_ok: begin
          status_d[STATUS_BAD_ADDR] = 1'b1;
          if (is_get) resp_d = {status_q, fr.addr, 8'h00};
        end
        is_get && addr_ok: begin
          resp_d   = {status_q, fr.addr, PAYLOAD_BITS'(rd_bright)};
          status_d = '0;
        end
        default: begin end
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      rx_q     <= '0;
      tx_q     <= '0;
      resp_q   <= '0;
      bitcnt_q <= '0;
      status_q <= '0;
      rx_dv_q  <= 1'b0;
    end else begin
      rx_dv_q  <= commit;
      status_q <= status_d;
      resp_q   <= resp_d;
      if (state_q == RX_IDLE && cs_fall) begin
        bitcnt_q <= '0;
        tx_q     <= resp_q;
      end
      if (state_q == RX_RECV && sclk_rise) begin
        rx_q <= {rx_q[FRAME_WIDTH-2:0], mosi_s};
        if (bitcnt_q != LEN_SAT) bitcnt_q <= bitcnt_q + 1'b1;
      end
      if (state_q == RX_RECV && sclk_fall)
        tx_q <= {tx_q[FRAME_WIDTH-2:0], 1'b0};
    end
  end

  assign tick = pre_q == PRE_MAX;

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      pre_q <= '0;
    end else begin
      cnt_q <= (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      pre_q <= tick ? '0 : pre_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    led_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .clk_i    (sysclk),
      .rst_ni   (rst_n),
      .cnt_i    (cnt_q),
      .tick_i   (tick),
      .set_i    (set_we[i]),
      .fade_i   (fade_we[i]),
      .data_i   (wr_data),
      .bright_o (bright[i]),
      .led_o    (led[i])
    );
  end

  assign spi.miso = (state_q == RX_RECV) & tx_q[FRAME_WIDTH-1];
  assign rx_dv    = rx_dv_q;
endmodule
